// File: rtl/reg_scan.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : reg_scan
// Purpose  : Debug scan engine that dumps the register file as a byte stream
//            or loads it from one, in ascending address order.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scan #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_LOAD = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] c_one      = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_idx;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    logic w_capture;
    logic w_out_hs;
    logic w_in_hs;

    // A new byte may be fetched whenever the output slot is empty or draining.
    assign w_capture = (r_state == S_DUMP) && (r_idx < c_num_regs)
                       && (!r_out_valid || out_ready);
    assign w_out_hs  = (r_state == S_DUMP) && r_out_valid && out_ready;
    assign w_in_hs   = (r_state == S_LOAD) && in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = mode ? S_LOAD : S_DUMP;
                end
            end
            S_DUMP: begin
                busy = 1'b1;
                if (w_out_hs && r_out_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (w_in_hs && (r_idx == c_last_idx)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                end
                S_DUMP: begin
                    if (w_capture) begin
                        r_out_data  <= rd_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == c_last_idx);
                        r_idx       <= r_idx + c_one;
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx[ADDR_W-1:0];
                        r_wr_data <= in_data;
                        r_idx     <= r_idx + c_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Counter overflow bit is dropped; the address is don't-care once idx hits NUM_REGS.
    assign rd_addr   = r_idx[ADDR_W-1:0];
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_scan.sv
`timescale 1ns / 1ps
`default_nettype none
// Testbench for reg_scan: random-driven dump/load sequences checked against a
// register-array model and the stream ordering rules.
module tb_reg_scan;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              in_ready;

    logic [DATA_W-1:0] rf       [NUM_REGS];
    logic [DATA_W-1:0] pre_vals [NUM_REGS];
    logic              pre_en = 1'b0;
    logic [DATA_W-1:0] exp_regs [NUM_REGS];

    int checks   = 0;
    int failures = 0;

    reg_scan #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data)
    );

    always #5 clk = ~clk;

    // Register file beside the engine; not reset, backdoor preload port.
    assign rd_data = rf[rd_addr];
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= pre_vals[i];
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_done",      32'(done),      32'd0);
        check_eq("rst_wr_en",     32'(wr_en),     32'd0);
        check_eq("rst_wr_addr",   32'(wr_addr),   32'd0);
        check_eq("rst_wr_data",   32'(wr_data),   32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last",  32'(out_last),  32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_rd_addr",   32'(rd_addr),   32'd0);
    endtask

    task automatic preload(input logic [DATA_W-1:0] base);
        for (int i = 0; i < NUM_REGS; i++) begin
            pre_vals[i] = base + DATA_W'(i);
            exp_regs[i] = base + DATA_W'(i);
        end
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    // rmode: 0 = ready always high, 1 = toggling, 2 = random
    task automatic run_dump(input int rmode, input bit poke);
        int n        = 0;
        int cyc      = 0;
        int first_v  = -1;
        int done_cyc = -1;
        int last_hs  = -1;
        int ndone    = 0;
        start = 1'b1; mode = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && done_cyc < 0) begin
            start = poke && (cyc == 5);
            mode  = poke;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check_eq("dump_busy",     32'(busy),     32'd1);
            check_eq("dump_wr_en",    32'(wr_en),    32'd0);
            check_eq("dump_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (n < NUM_REGS) begin
                    check_eq("dump_data", 32'(out_data), 32'(exp_regs[n]));
                    check_eq("dump_last", 32'(out_last), 32'(n == NUM_REGS - 1));
                end else begin
                    check_eq("dump_extra_byte", 32'(n), 32'(NUM_REGS - 1));
                end
                if (out_ready) begin
                    n++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            tick();
            cyc++;
        end
        start = 1'b0; mode = 1'b0; out_ready = 1'b0;
        check_eq("dump_done_count", 32'(ndone),    32'd1);
        check_eq("dump_byte_count", 32'(n),        32'(NUM_REGS));
        check_eq("dump_done_after", 32'(done_cyc), 32'(last_hs + 1));
        check_eq("dump_busy_fall",  32'(busy),     32'd0);
        check_eq("dump_done_once",  32'(done),     32'd0);
        if (rmode == 0) begin
            check_eq("dump_first_valid_cyc", 32'(first_v),  32'd2);
            check_eq("dump_done_cyc",        32'(done_cyc), 32'(NUM_REGS + 2));
        end
    endtask

    // vmode: 0 = valid always high, 1 = gap every third cycle, 2 = random
    task automatic run_load(input int vmode, input int nbytes, input int reset_after,
                            input logic [DATA_W-1:0] base, input bit rnd);
        logic [DATA_W-1:0] src [20];
        logic [DATA_W-1:0] pend_data = '0;
        int pend_addr = 0;
        bit pend      = 1'b0;
        bit hs;
        bit exp_done;
        int acc       = 0;
        int sent      = 0;
        int cyc       = 0;
        int done_cyc  = -1;
        int ndone     = 0;
        int extra     = (nbytes > NUM_REGS) ? 4 : 1;
        for (int i = 0; i < 20; i++) src[i] = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        cyc = 1;
        while (cyc < 400 && !(done_cyc >= 0 && cyc > done_cyc + extra)) begin
            check_eq("ld_wr_en", 32'(wr_en), 32'(pend));
            if (pend) begin
                check_eq("ld_wr_addr", 32'(wr_addr), 32'(pend_addr));
                check_eq("ld_wr_data", 32'(wr_data), 32'(pend_data));
                exp_regs[pend_addr] = pend_data;
            end
            check_eq("ld_in_ready",  32'(in_ready),  32'(acc < NUM_REGS));
            check_eq("ld_out_valid", 32'(out_valid), 32'd0);
            if (reset_after > 0 && acc == reset_after) begin
                reset = 1'b1; in_valid = 1'b1; in_data = DATA_W'($urandom);
                tick();
                check_reset_outputs();
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check_eq("rst_after_wr_en", 32'(wr_en), 32'd0);
                    check_eq("rst_after_done",  32'(done),  32'd0);
                    check_eq("rst_after_busy",  32'(busy),  32'd0);
                end
                in_valid = 1'b0;
                return;
            end
            exp_done = pend && (acc == NUM_REGS);
            check_eq("ld_done", 32'(done), 32'(exp_done));
            check_eq("ld_busy", 32'(busy), 32'(done_cyc < 0));
            if (done) ndone++;
            if (exp_done) done_cyc = cyc;
            case (vmode)
                0:       in_valid = (sent < nbytes);
                1:       in_valid = (sent < nbytes) && (cyc % 3 != 0);
                default: in_valid = (sent < nbytes) && 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? src[sent] : DATA_W'($urandom);
            hs = in_valid && (acc < NUM_REGS);
            pend = hs;
            if (hs) begin
                pend_addr = acc;
                pend_data = in_data;
                acc++;
            end
            if (in_valid && (hs || acc >= NUM_REGS)) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("ld_done_count", 32'(ndone), 32'd1);
        check_eq("ld_accepted",   32'(acc),   32'(NUM_REGS));
        if (vmode == 0) check_eq("ld_done_cyc", 32'(done_cyc), 32'(NUM_REGS + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        preload(8'h10);
        run_dump(0, 1'b0);
        run_dump(1, 1'b0);

        run_load(1, NUM_REGS, 0, 8'hA0, 1'b0);
        run_dump(0, 1'b0);

        run_dump(0, 1'b1);

        run_load(2, NUM_REGS, 0, 8'h00, 1'b1);
        run_dump(2, 1'b0);

        run_load(0, NUM_REGS, 5, 8'h50, 1'b1);
        run_dump(0, 1'b0);

        run_load(0, 20, 0, 8'hC0, 1'b0);
        run_dump(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
